matrix_ascii_rx: RTL and testbench
==================================

MATRIX_ASCII_RX -- requirements
Module: matrix_ascii_rx

Interface
REQ-001 Parameter ELEM_WIDTH, default 8, SHALL be the bit width of one stored element.
REQ-002 Parameter MAX_DIM, default 5, SHALL be the maximum row or column count.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle request that begins a new matrix capture.
REQ-006 m  input  4  SHALL give the row count; sampled only on an accepted start.
REQ-007 n  input  4  SHALL give the column count; sampled only on an accepted start.
REQ-008 rx_valid  input  1  SHALL mark the one cycle in which rx_data holds a received UART byte.
REQ-009 rx_data  input  8  SHALL carry the received ASCII byte.
REQ-010 out_matrix  output  200  SHALL hold the packed 5x5 element array; element k is at bits [k*8 +: 8], row-major k = r*n + c.
REQ-011 elem_cnt  output  5  SHALL give the number of elements stored in the current capture.
REQ-012 busy  output  1  SHALL be high from the accepted start until done or error.
REQ-013 done  output  1  SHALL be a one-cycle pulse when m*n elements have been stored.
REQ-014 error  output  1  SHALL be a one-cycle pulse when a capture aborts.

Function
REQ-015 The FSM SHALL have states IDLE, COLLECT, FINISH and FAIL.
REQ-016 In IDLE, start SHALL be accepted and the FSM SHALL enter COLLECT next cycle, with m and n latched, all 25 elements cleared to 0, elem_cnt = 0, accumulator = 0 and digit_seen = 0.
REQ-017 If the latched m or n is 0 or greater than MAX_DIM, the FSM SHALL go to FAIL instead of COLLECT.
REQ-018 start SHALL be ignored while busy; rx_valid SHALL be ignored in IDLE.
REQ-019 In COLLECT, an rx_valid byte '0'..'9' (0x30..0x39) SHALL update the accumulator to acc*10 + digit and set digit_seen; the accumulator SHALL be 10 bits wide.
REQ-020 A separator byte (0x20 space, 0x0D CR, 0x0A LF, 0x2C comma) with digit_seen=1 SHALL write the accumulator to element elem_cnt, increment elem_cnt, and clear the accumulator and digit_seen, all in the same cycle.
REQ-021 A separator byte with digit_seen=0 SHALL be ignored, so repeated whitespace and blank lines are legal.
REQ-022 The row/column position SHALL come only from elem_cnt; the position of LF in the stream SHALL have no effect.
REQ-023 When elem_cnt reaches m*n, the FSM SHALL enter FINISH, and done SHALL pulse exactly one cycle after the final separator's rx_valid; busy SHALL fall in the same cycle.
REQ-024 Any other byte in COLLECT, or an accumulator value above 255 at a digit, SHALL send the FSM to FAIL.
REQ-025 FAIL SHALL pulse error for one cycle, clear busy and return to IDLE; elements already stored SHALL stay in out_matrix.
REQ-026 out_matrix and elem_cnt SHALL hold their values in IDLE until the next accepted start.
REQ-027 Bytes received after done SHALL be ignored.
REQ-028 The block SHALL accept one rx_valid byte per cycle, back to back, with no dropped bytes.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE; out_matrix, elem_cnt, accumulator and digit_seen SHALL clear to 0; busy, done and error SHALL clear to 0.
REQ-030 rst SHALL take priority over start and rx_valid, including during a capture.

Configuration
REQ-031 With RX_VALUE_CLAMP_EN defined, an accumulator value above 255 SHALL saturate to 255 and stay there until the separator, and no error SHALL be raised.
REQ-032 Without RX_VALUE_CLAMP_EN, an accumulator value above 255 SHALL raise error as in REQ-024.

Verification
REQ-033 m=2, n=3, stream "1 2 3\n4 5 6\n" -> done pulse one cycle after the last 0x0A; elements 0..5 = 1..6; elem_cnt=6; busy low.
REQ-034 m=2, n=2, stream "  10,,20\r\n\n30 255 " -> elements = 10, 20, 30, 255; done asserted.
REQ-035 m=1, n=2, stream "7 x" -> error pulse on the cycle after 'x'; element0 = 7; no done.
REQ-036 m=1, n=1, stream "300 " -> error without RX_VALUE_CLAMP_EN; element0 = 255 and done with RX_VALUE_CLAMP_EN.
REQ-037 m=6, n=2, start -> error pulse, busy never observed high after FAIL, out_matrix all zero.
REQ-038 rst asserted after 2 of 4 elements, then start with m=2, n=2 and stream "9 8 7 6 " -> out_matrix holds only 9, 8, 7, 6; done pulse.

Source files
------------

// File: rtl/matrix_ascii_rx_if.sv
// Bundle of the capture request, UART byte strobe and matrix result signals.
// The master side drives start/dimensions/bytes; the slave side (the receiver) returns the matrix.
interface matrix_ascii_rx_if #(
    parameter int ELEM_WIDTH = 8,
    parameter int MAX_DIM    = 5
);
    localparam int CNT_W = $clog2(MAX_DIM * MAX_DIM + 1);

    logic                                   start;
    logic [3:0]                             m;
    logic [3:0]                             n;
    logic                                   rx_valid;
    logic [7:0]                             rx_data;
    logic [ELEM_WIDTH*MAX_DIM*MAX_DIM-1:0]  out_matrix;
    logic [CNT_W-1:0]                       elem_cnt;
    logic                                   busy;
    logic                                   done;
    logic                                   error;

    modport master (
        output start, m, n, rx_valid, rx_data,
        input  out_matrix, elem_cnt, busy, done, error
    );

    modport slave (
        input  start, m, n, rx_valid, rx_data,
        output out_matrix, elem_cnt, busy, done, error
    );
endinterface

// File: rtl/matrix_ascii_rx.sv
// Parses ASCII decimal numbers from a UART byte stream into an m x n matrix; RX_VALUE_CLAMP_EN saturates values >255.
// Latency: done/error one cycle after the terminating byte; accepts one byte per cycle, no backpressure.
module matrix_ascii_rx #(
    parameter int ELEM_WIDTH = 8,
    parameter int MAX_DIM    = 5
) (
    input  logic             clk,
    input  logic             rst,
    matrix_ascii_rx_if.slave bus
);
    localparam int              NUM_ELEM = MAX_DIM * MAX_DIM;
    localparam int              CNT_W    = $clog2(NUM_ELEM + 1);
    localparam logic [3:0]      MAX_DIM4 = 4'(MAX_DIM);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, COLLECT, FINISH, FAIL} state_t;

    state_t                state_q, state_d;
    logic [3:0]            m_q, m_d;
    logic [3:0]            n_q, n_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [9:0]            acc_q, acc_d;
    logic                  seen_q, seen_d;
    logic [ELEM_WIDTH-1:0] elem_q [NUM_ELEM];
    logic [ELEM_WIDTH-1:0] elem_d [NUM_ELEM];

    logic        is_digit;
    logic        is_sep;
    logic        dims_bad;
    logic [11:0] acc_next;
    logic [7:0]  total;

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        seen_d   = seen_q;
        elem_d   = elem_q;
        is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
        is_sep   = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) ||
                   (bus.rx_data == 8'h0A) || (bus.rx_data == 8'h2C);
        // acc_q never exceeds 255, so 12 bits hold acc*10+9 without wrap
        acc_next = 12'(acc_q) * 12'd10 + 12'(bus.rx_data - 8'h30);
        dims_bad = (bus.m == 4'd0) || (bus.m > MAX_DIM4) ||
                   (bus.n == 4'd0) || (bus.n > MAX_DIM4);
        total    = 8'(m_q) * 8'(n_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d    = bus.m;
                    n_d    = bus.n;
                    cnt_d  = '0;
                    acc_d  = '0;
                    seen_d = 1'b0;
                    for (int k = 0; k < NUM_ELEM; k++) elem_d[k] = '0;
                    state_d = dims_bad ? FAIL : COLLECT;
                end
            end
            COLLECT: begin
                if (bus.rx_valid) begin
                    if (is_digit) begin
                        if (acc_next > 12'd255) begin
`ifdef RX_VALUE_CLAMP_EN
                            acc_d  = 10'd255;
                            seen_d = 1'b1;
`else
                            state_d = FAIL;
`endif
                        end else begin
                            acc_d  = acc_next[9:0];
                            seen_d = 1'b1;
                        end
                    end else if (is_sep) begin
                        if (seen_q) begin
                            elem_d[cnt_q] = ELEM_WIDTH'(acc_q);
                            cnt_d  = cnt_q + CNT_ONE;
                            acc_d  = '0;
                            seen_d = 1'b0;
                            if (8'(cnt_q) + 8'd1 == total) state_d = FINISH;
                        end
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            seen_q  <= 1'b0;
            for (int k = 0; k < NUM_ELEM; k++) elem_q[k] <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            seen_q  <= seen_d;
            elem_q  <= elem_d;
        end
    end

    assign bus.busy     = (state_q == COLLECT);
    assign bus.done     = (state_q == FINISH);
    assign bus.error    = (state_q == FAIL);
    assign bus.elem_cnt = cnt_q;

    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_out
        assign bus.out_matrix[k*ELEM_WIDTH +: ELEM_WIDTH] = elem_q[k];
    end
endmodule

// File: tb/tb_matrix_ascii_rx.sv
// Bench for matrix_ascii_rx: directed and random ASCII streams compared against a token-level parser model.
module tb_matrix_ascii_rx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_ascii_rx_if bus ();
    matrix_ascii_rx dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] stream[$];
    int exp_el[25];
    int exp_cnt, exp_done_pos, exp_err_pos, term;
    int done_n, err_n, obs_done_pos, obs_err_pos, busy_bad;
    logic [7:0] seps[4] = '{8'h20, 8'h0D, 8'h0A, 8'h2C};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_str(input string s);
        foreach (s[i]) stream.push_back(s[i]);
    endtask

    // Reference: walk the text as tokens of decimal digits split by separators.
    task automatic model(input int mm, input int nn);
        int cur, v;
        bit have, stop;
        for (int k = 0; k < 25; k++) exp_el[k] = 0;
        exp_cnt = 0; exp_done_pos = -2; exp_err_pos = -2;
        if (mm < 1 || mm > 5 || nn < 1 || nn > 5) begin
            exp_err_pos = -1;
            return;
        end
        cur = 0; have = 0; stop = 0;
        for (int i = 0; i < stream.size() && !stop; i++) begin
            int c;
            c = int'(stream[i]);
            if (c >= 48 && c <= 57) begin
                v = cur * 10 + (c - 48);
                if (v > 255) begin
`ifdef RX_VALUE_CLAMP_EN
                    v = 255;
`else
                    exp_err_pos = i; stop = 1;
`endif
                end
                cur = v; have = 1;
            end else if (c == 32 || c == 13 || c == 10 || c == 44) begin
                if (have) begin
                    exp_el[exp_cnt] = cur;
                    exp_cnt++;
                    cur = 0; have = 0;
                    if (exp_cnt == mm * nn) begin exp_done_pos = i; stop = 1; end
                end
            end else begin
                exp_err_pos = i; stop = 1;
            end
        end
    endtask

    task automatic sample(input int pos);
        bit exp_busy;
        if (bus.done === 1'b1) begin
            done_n++;
            if (obs_done_pos == -2) obs_done_pos = pos;
        end
        if (bus.error === 1'b1) begin
            err_n++;
            if (obs_err_pos == -2) obs_err_pos = pos;
        end
        exp_busy = (exp_err_pos != -1) && (pos < term);
        if (bus.busy !== exp_busy) busy_bad++;
    endtask

    task automatic run_capture(input int mm, input int nn, input string tag);
        logic [199:0] exp_pk;
        int pos;
        model(mm, nn);
        term = (exp_done_pos != -2) ? exp_done_pos : exp_err_pos;
        done_n = 0; err_n = 0; obs_done_pos = -2; obs_err_pos = -2; busy_bad = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.m = 4'(mm); bus.n = 4'(nn);
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy_after_start"}, 256'(bus.busy), 256'(exp_err_pos != -1));
        sample(-1);
        for (int i = 0; i < stream.size(); i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = stream[i];
            // A start while capturing must not disturb the capture
            if (i == 0 && term > 0) begin
                bus.start = 1'b1; bus.m = 4'd1; bus.n = 4'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            sample(i);
        end
        bus.rx_valid = 1'b0; bus.start = 1'b0;
        pos = stream.size();
        repeat (3) begin
            @(negedge clk);
            sample(pos);
            pos++;
        end
        exp_pk = '0;
        for (int k = 0; k < 25; k++) exp_pk[k*8 +: 8] = exp_el[k][7:0];
        chk({tag, "_done_count"}, 256'(done_n), 256'(exp_done_pos >= 0 ? 1 : 0));
        chk({tag, "_done_pos"},   256'(obs_done_pos), 256'(exp_done_pos));
        chk({tag, "_err_count"},  256'(err_n), 256'(exp_err_pos != -2 ? 1 : 0));
        chk({tag, "_err_pos"},    256'(obs_err_pos), 256'(exp_err_pos));
        chk({tag, "_elem_cnt"},   256'(bus.elem_cnt), 256'(exp_cnt));
        chk({tag, "_out_matrix"}, 256'(bus.out_matrix), 256'(exp_pk));
        chk({tag, "_busy_track"}, 256'(busy_bad), 256'(0));
        stream.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.m = '0; bus.n = '0; bus.rx_valid = 1'b0; bus.rx_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy",  256'(bus.busy), 256'(0));
        chk("reset_done",  256'(bus.done), 256'(0));
        chk("reset_error", 256'(bus.error), 256'(0));
        chk("reset_cnt",   256'(bus.elem_cnt), 256'(0));
        chk("reset_out",   256'(bus.out_matrix), 256'(0));

        push_str("1 2 3\n4 5 6\n");          run_capture(2, 3, "d_2x3");
        push_str("  10,,20\r\n\n30 255 ");    run_capture(2, 2, "d_blank");
        push_str("7 x");                      run_capture(1, 2, "d_badchar");
        push_str("300 ");                     run_capture(1, 1, "d_over");
        push_str("1 2 ");                     run_capture(6, 2, "d_baddim");

        // Reset mid-capture, with a byte presented in the same cycle
        @(negedge clk);
        bus.start = 1'b1; bus.m = 4'd2; bus.n = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        push_str("1 2 ");
        foreach (stream[i]) begin
            bus.rx_valid = 1'b1; bus.rx_data = stream[i];
            @(negedge clk);
        end
        stream.delete();
        chk("mid_cnt", 256'(bus.elem_cnt), 256'(2));
        rst = 1'b1; bus.rx_data = 8'h33;
        @(negedge clk);
        rst = 1'b0; bus.rx_valid = 1'b0;
        chk("mid_rst_busy", 256'(bus.busy), 256'(0));
        chk("mid_rst_cnt",  256'(bus.elem_cnt), 256'(0));
        chk("mid_rst_out",  256'(bus.out_matrix), 256'(0));
        push_str("9 8 7 6 ");                 run_capture(2, 2, "d_after_rst");

        for (int r = 0; r < 24; r++) begin
            int mm, nn, ntok;
            if ($urandom_range(0, 7) == 0) mm = $urandom_range(0, 1) ? 0 : $urandom_range(6, 15);
            else mm = $urandom_range(1, 5);
            if ($urandom_range(0, 7) == 0) nn = $urandom_range(0, 1) ? 0 : $urandom_range(6, 15);
            else nn = $urandom_range(1, 5);
            ntok = (mm >= 1 && mm <= 5 && nn >= 1 && nn <= 5) ? mm * nn + $urandom_range(0, 2) : 2;
            repeat ($urandom_range(0, 2)) stream.push_back(seps[$urandom_range(0, 3)]);
            for (int t = 0; t < ntok; t++) begin
                int v;
                v = ($urandom_range(0, 15) == 0) ? $urandom_range(256, 999) : $urandom_range(0, 255);
                push_str($sformatf("%0d", v));
                if ($urandom_range(0, 39) == 0) stream.push_back($urandom_range(0, 1) ? 8'h78 : 8'h2D);
                repeat ($urandom_range(1, 2)) stream.push_back(seps[$urandom_range(0, 3)]);
            end
            run_capture(mm, nn, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
